// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch front end
package fetch_pkg;

  localparam int FETCH_XLEN    = 32;
  localparam int DEFAULT_DEPTH = 4;

  // Address fetching starts from after reset.
  localparam logic [FETCH_XLEN-1:0] RESET_PC = '0;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] instr;
    logic [FETCH_XLEN-1:0] addr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - circular instruction queue with push, pop and flush
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   flush       empty the queue (wins over push/pop)
//   push        write push_data at the tail
//   push_data   entry to write
//   pop         advance the head (caller guarantees the queue is non-empty)
//   head_data   entry at the head, valid when count != 0
//   count       occupancy, 0..DEPTH
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH = DEFAULT_DEPTH,
  parameter type T     = fetch_entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  T                         push_data,
  input  logic                     pop,
  output T                         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  T              mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  // Pointers wrap naturally because DEPTH is a power of two. When full,
  // head == tail, so a simultaneous push overwrites exactly the slot being
  // popped; the read of the old head value happens before the write lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: nothing is visible unless count covers it.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[tail] <= push_data;
  end

  assign head_data = mem[head];

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - sequential instruction fetch with buffered queue and flush/redirect
//
// Optional feature macro: FETCH_QUEUE_BYPASS_EN (present an accepted response
// to the Decoder in the same cycle when the queue is empty).
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   rdy              global ready; low freezes all state
//   rob_clear        flush from the RoB, restart at back_pc
//   back_pc          restart address for rob_clear
//   start_fetch      request valid to the instruction cache
//   pc               request address to the instruction cache
//   instr_ready_in   cache response valid
//   instr_in         cache response instruction
//   instr_addr_in    address the cache response belongs to
//   redirect         Decoder predicted-taken, restart at predictor_pc
//   predictor_pc     redirect target
//   instr_issued     Decoder consumed the head this cycle
//   instr_ready      head valid toward the Decoder
//   instr            head instruction (0 when not valid)
//   instr_addr       head address (0 when not valid)
//   count            queue occupancy
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int XLEN  = FETCH_XLEN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   rob_clear,
  input  logic [XLEN-1:0]        back_pc,
  output logic                   start_fetch,
  output logic [XLEN-1:0]        pc,
  input  logic                   instr_ready_in,
  input  logic [XLEN-1:0]        instr_in,
  input  logic [XLEN-1:0]        instr_addr_in,
  input  logic                   redirect,
  input  logic [XLEN-1:0]        predictor_pc,
  input  logic                   instr_issued,
  output logic                   instr_ready,
  output logic [XLEN-1:0]        instr,
  output logic [XLEN-1:0]        instr_addr,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] addr;
  } entry_t;

  entry_t        head_entry;
  entry_t        push_entry;
  logic [CW-1:0] q_count;
  logic          q_valid;
  logic          room;
  logic          flushing;
  logic          normal;
  logic          match;
  logic          head_pop;
  logic          accept;
  logic          push;
  logic          bypass;

  assign q_valid  = (q_count != '0);
  assign room     = (q_count < CW'(DEPTH));
  assign flushing = rdy && (rob_clear || redirect);
  assign normal   = rdy && !rob_clear && !redirect;

  // Only a response for the currently requested pc is taken; anything else
  // is a stale reply to a request issued before a flush or a refetch.
  assign match    = instr_ready_in && (instr_addr_in == pc);
  assign head_pop = normal && instr_issued && q_valid;

  // A pop in the same cycle frees a slot, so a full queue can still accept.
  assign accept   = normal && match && (room || head_pop);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = accept && !q_valid;
  // A bypassed response that the Decoder consumes right away never lands.
  assign push   = accept && !(bypass && instr_issued);
`else
  assign bypass = 1'b0;
  assign push   = accept;
`endif

  assign push_entry = '{instr: instr_in, addr: pc};

  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flushing),
    .push      (push),
    .push_data (push_entry),
    .pop       (head_pop),
    .head_data (head_entry),
    .count     (q_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= XLEN'(RESET_PC);
    end else if (rdy) begin
      if (rob_clear)     pc <= back_pc;
      else if (redirect) pc <= predictor_pc;
      else if (accept)   pc <= pc + XLEN'(4);
    end
  end

  always_comb begin
    instr_ready = 1'b0;
    instr       = '0;
    instr_addr  = '0;
    if (q_valid) begin
      instr_ready = 1'b1;
      instr       = head_entry.instr;
      instr_addr  = head_entry.addr;
    end else if (bypass) begin
      instr_ready = 1'b1;
      instr       = instr_in;
      instr_addr  = pc;
    end
  end

  assign start_fetch = room && !rob_clear && !redirect;
  assign count       = q_count;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            rdy;
  logic            rob_clear;
  logic [XLEN-1:0] back_pc;
  logic            start_fetch;
  logic [XLEN-1:0] pc;
  logic            instr_ready_in;
  logic [XLEN-1:0] instr_in;
  logic [XLEN-1:0] instr_addr_in;
  logic            redirect;
  logic [XLEN-1:0] predictor_pc;
  logic            instr_issued;
  logic            instr_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_addr;
  logic [2:0]      count;

  int tests_run    = 0;
  int tests_failed = 0;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .rob_clear      (rob_clear),
    .back_pc        (back_pc),
    .start_fetch    (start_fetch),
    .pc             (pc),
    .instr_ready_in (instr_ready_in),
    .instr_in       (instr_in),
    .instr_addr_in  (instr_addr_in),
    .redirect       (redirect),
    .predictor_pc   (predictor_pc),
    .instr_issued   (instr_issued),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_addr     (instr_addr),
    .count          (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rob_clear      = 1'b0;
    back_pc        = '0;
    instr_ready_in = 1'b0;
    instr_in       = '0;
    instr_addr_in  = '0;
    redirect       = 1'b0;
    predictor_pc   = '0;
    instr_issued   = 1'b0;
  endtask

  task automatic respond(input logic [31:0] addr, input logic [31:0] data);
    instr_ready_in = 1'b1;
    instr_addr_in  = addr;
    instr_in       = data;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rdy = 1'b1;
    idle();
    #1;
    tests_run++; if (count !== 3'd0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", count); end
    tests_run++; if (instr_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_instr_ready: got %b expected 0", instr_ready); end
    tests_run++; if (instr !== 32'h0 || instr_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_head: got %h/%h expected 0/0", instr, instr_addr); end
    tests_run++; if (pc !== 32'h0) begin tests_failed++; $display("FAIL reset_pc: got %h expected 0", pc); end
    tick();
    rst = 1'b0;
    #1;
    tests_run++; if (start_fetch !== 1'b1) begin tests_failed++; $display("FAIL reset_start_fetch: got %b expected 1", start_fetch); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      respond(32'(4 * i), 32'hA000 + 32'(i));
      tick();
      tests_run++; if (count !== 3'(i + 1)) begin tests_failed++; $display("FAIL fill_count_%0d: got %0d expected %0d", i, count, i + 1); end
    end
    idle();
    #1;
    tests_run++; if (start_fetch !== 1'b0) begin tests_failed++; $display("FAIL fill_start_fetch: got %b expected 0", start_fetch); end
    tests_run++; if (instr_addr !== 32'h0 || instr !== 32'hA000) begin tests_failed++; $display("FAIL fill_head: got %h/%h expected 0/a000", instr_addr, instr); end
    respond(32'h10, 32'hBEEF);
    tick();
    idle();
    tests_run++; if (count !== 3'd4) begin tests_failed++; $display("FAIL full_drop_count: got %0d expected 4", count); end
    tests_run++; if (pc !== 32'h10) begin tests_failed++; $display("FAIL full_drop_pc: got %h expected 10", pc); end
  endtask

  task automatic test_full_push_pop();
    respond(32'h10, 32'hA004);
    instr_issued = 1'b1;
    tick();
    idle();
    tests_run++; if (count !== 3'd4) begin tests_failed++; $display("FAIL fullpp_count: got %0d expected 4", count); end
    tests_run++; if (instr_addr !== 32'h4 || instr !== 32'hA001) begin tests_failed++; $display("FAIL fullpp_head: got %h/%h expected 4/a001", instr_addr, instr); end
    tests_run++; if (pc !== 32'h14) begin tests_failed++; $display("FAIL fullpp_pc: got %h expected 14", pc); end
    instr_issued = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    idle();
    #1;
    tests_run++; if (count !== 3'd1) begin tests_failed++; $display("FAIL fullpp_drain_count: got %0d expected 1", count); end
    tests_run++; if (instr_addr !== 32'h10 || instr !== 32'hA004) begin tests_failed++; $display("FAIL fullpp_tail: got %h/%h expected 10/a004", instr_addr, instr); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      respond(32'h14 + 32'(4 * i), 32'hC000 + 32'(i));
      instr_issued = 1'b1;
      tick();
      tests_run++; if (instr_addr !== 32'h14 + 32'(4 * i) || count !== 3'd1) begin tests_failed++; $display("FAIL b2b_%0d: got addr %h count %0d expected addr %h count 1", i, instr_addr, count, 32'h14 + 32'(4 * i)); end
    end
    idle();
    tests_run++; if (pc !== 32'h24) begin tests_failed++; $display("FAIL b2b_pc: got %h expected 24", pc); end
  endtask

  task automatic test_mismatch();
    respond(32'h20, 32'hDEAD);
    tick();
    idle();
    tests_run++; if (count !== 3'd1 || pc !== 32'h24) begin tests_failed++; $display("FAIL mismatch: got count %0d pc %h expected count 1 pc 24", count, pc); end
  endtask

  task automatic test_rob_clear();
    respond(32'h24, 32'hC004);
    tick();
    tests_run++; if (count !== 3'd2) begin tests_failed++; $display("FAIL clr_pre_count: got %0d expected 2", count); end
    respond(32'h28, 32'hC005);
    instr_issued = 1'b1;
    rob_clear    = 1'b1;
    back_pc      = 32'h100;
    #1;
    tests_run++; if (start_fetch !== 1'b0) begin tests_failed++; $display("FAIL clr_start_fetch: got %b expected 0", start_fetch); end
    tick();
    idle();
    #1;
    tests_run++; if (count !== 3'd0 || instr_ready !== 1'b0) begin tests_failed++; $display("FAIL clr_empty: got count %0d ready %b expected 0/0", count, instr_ready); end
    tests_run++; if (pc !== 32'h100 || start_fetch !== 1'b1) begin tests_failed++; $display("FAIL clr_pc: got pc %h sf %b expected 100/1", pc, start_fetch); end
    respond(32'h100, 32'hD000);
    tick();
    idle();
    tests_run++; if (count !== 3'd1 || instr_addr !== 32'h100 || pc !== 32'h104) begin tests_failed++; $display("FAIL clr_refetch: got count %0d addr %h pc %h expected 1/100/104", count, instr_addr, pc); end
  endtask

  task automatic test_redirect();
    respond(32'h104, 32'hD001); tick();
    respond(32'h108, 32'hD002); tick();
    idle();
    tests_run++; if (count !== 3'd3) begin tests_failed++; $display("FAIL redir_pre_count: got %0d expected 3", count); end
    redirect     = 1'b1;
    predictor_pc = 32'h40;
    instr_issued = 1'b1;
    respond(32'h10C, 32'hD003);
    tick();
    idle();
    tests_run++; if (count !== 3'd0 || pc !== 32'h40) begin tests_failed++; $display("FAIL redir: got count %0d pc %h expected 0/40", count, pc); end
    respond(32'h10, 32'hEEEE);
    tick();
    idle();
    tests_run++; if (count !== 3'd0 || pc !== 32'h40) begin tests_failed++; $display("FAIL redir_stale: got count %0d pc %h expected 0/40", count, pc); end
  endtask

  task automatic test_hold();
    respond(32'h40, 32'hF000);
    tick();
    idle();
    rdy = 1'b0;
    respond(32'h44, 32'hF001);
    instr_issued = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++; if (count !== 3'd1 || pc !== 32'h44 || instr_addr !== 32'h40) begin tests_failed++; $display("FAIL hold_%0d: got count %0d pc %h addr %h expected 1/44/40", i, count, pc, instr_addr); end
    end
    idle();
    rdy = 1'b1;
    instr_issued = 1'b1;
    tick();
    idle();
    tests_run++; if (count !== 3'd0) begin tests_failed++; $display("FAIL hold_release_pop: got %0d expected 0", count); end
  endtask

  task automatic test_empty_response();
    rob_clear = 1'b1;
    back_pc   = 32'h0;
    tick();
    idle();
    respond(32'h0, 32'h1234);
    instr_issued = 1'b1;
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    tests_run++; if (instr_ready !== 1'b1 || instr_addr !== 32'h0 || instr !== 32'h1234) begin tests_failed++; $display("FAIL bypass_same_cycle: got %b/%h/%h expected 1/0/1234", instr_ready, instr_addr, instr); end
    tick();
    idle();
    tests_run++; if (count !== 3'd0 || pc !== 32'h4) begin tests_failed++; $display("FAIL bypass_after: got count %0d pc %h expected 0/4", count, pc); end
`else
    tests_run++; if (instr_ready !== 1'b0) begin tests_failed++; $display("FAIL latency_same_cycle: got %b expected 0", instr_ready); end
    tick();
    idle();
    tests_run++; if (count !== 3'd1 || instr_ready !== 1'b1 || instr !== 32'h1234 || pc !== 32'h4) begin tests_failed++; $display("FAIL latency_after: got count %0d ready %b instr %h pc %h expected 1/1/1234/4", count, instr_ready, instr, pc); end
`endif
  endtask

  task automatic test_async_reset();
    respond(32'h4, 32'h5555); tick();
    respond(32'h8, 32'h6666); tick();
    idle();
    #2;
    rst = 1'b1;
    #1;
    tests_run++; if (count !== 3'd0 || instr_ready !== 1'b0 || pc !== 32'h0) begin tests_failed++; $display("FAIL async_reset: got count %0d ready %b pc %h expected 0/0/0", count, instr_ready, pc); end
    tick();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_push_pop();
    test_back_to_back();
    test_mismatch();
    test_rob_clear();
    test_redirect();
    test_hold();
    test_empty_response();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
